// File: rtl/bus_master_arbiter_rv32_pkg.sv
// cpu_reg_package: arbiter state encoding, default parameters and counter sizing helper
package cpu_reg_package;
  typedef enum logic [2:0] {CPU_OWN, HALT_WAIT, EXT_OWN, DRAIN, RELEASE} arb_state_t;
  localparam int arb_address_width = 32;
  localparam int arb_data_width = 32;
  localparam int arb_halt_settle_cycles = 2;
  localparam int arb_max_grant_cycles = 256;
  localparam int arb_cpu_min_cycles = 16;
  function automatic int cnt_width(input int n);
    return n > 0 ? $clog2(n + 1) : 1;
  endfunction
endpackage

// File: rtl/bus_master_arbiter_rv32_sat_counter.sv
// arb_sat_counter: saturating up-counter with clear, enable and reached-limit flag
module arb_sat_counter #(
  parameter int width = 4,
  parameter int limit = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);
  logic [width-1:0] count;
  assign done = int'(count) >= limit;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clear) count <= '0;
    else if (en && !done) count <= count + 1'b1;
endmodule

// File: rtl/bus_master_arbiter_rv32.sv
// bus_master_arbiter_rv32: shares the RV32 bus between the CPU and one external master,
// halting the CPU while the external master performs single-beat reads and writes
module bus_master_arbiter_rv32
  import cpu_reg_package::*;
#(
  parameter int address_width = arb_address_width,
  parameter int data_width = arb_data_width,
  parameter int HaltSettleCycles = arb_halt_settle_cycles,
  parameter int MaxGrantCycles = arb_max_grant_cycles,
  parameter int CpuMinCycles = arb_cpu_min_cycles
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] cpu_address_i,
  input  logic [data_width-1:0]    cpu_data_i,
  input  logic                     cpu_we_i,
  input  logic [3:0]               cpu_we_ram_i,
  output logic                     cpu_halt_o,
  input  logic                     ext_req_i,
  output logic                     ext_grant_o,
  input  logic                     ext_valid_i,
  output logic                     ext_ready_o,
  input  logic                     ext_we_i,
  input  logic [3:0]               ext_be_i,
  input  logic [address_width-1:0] ext_address_i,
  input  logic [data_width-1:0]    ext_wdata_i,
  output logic                     ext_rvalid_o,
  output logic [data_width-1:0]    ext_rdata_o,
  output logic [address_width-1:0] bus_address_o,
  output logic [data_width-1:0]    bus_data_o,
  output logic                     bus_we_o,
  output logic [3:0]               bus_we_ram_o,
  input  logic [data_width-1:0]    bus_rdata_i
);
  arb_state_t state, next_state;
  logic rd_pend, settle_done, grant_done, dwell_done, limit, xfer, ext_side;
  logic [address_width-1:0] last_addr;
  arb_sat_counter #(.width(4), .limit(HaltSettleCycles - 1)) u_settle (
    .clk(clk_i), .rst(reset_i), .clear(state != HALT_WAIT), .en(state == HALT_WAIT), .done(settle_done)
  );
  arb_sat_counter #(.width(cnt_width(MaxGrantCycles)), .limit(MaxGrantCycles)) u_grant (
    .clk(clk_i), .rst(reset_i), .clear(state != EXT_OWN), .en(state == EXT_OWN), .done(grant_done)
  );
  arb_sat_counter #(.width(cnt_width(CpuMinCycles)), .limit(CpuMinCycles)) u_dwell (
    .clk(clk_i), .rst(reset_i), .clear(state == RELEASE), .en(state == CPU_OWN), .done(dwell_done)
  );
  assign limit = (MaxGrantCycles != 0) && grant_done;
  assign ext_side = state == EXT_OWN || state == DRAIN;
  assign xfer = state == EXT_OWN && !limit && ext_valid_i;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= CPU_OWN;
      rd_pend <= 1'b0;
      last_addr <= '0;
    end else begin
      state <= next_state;
      rd_pend <= xfer && !ext_we_i;
      last_addr <= xfer ? ext_address_i : last_addr;
    end
  always_comb begin
    next_state = state;
    case (state)
      CPU_OWN:   next_state = ext_req_i && dwell_done ? HALT_WAIT : CPU_OWN;
      HALT_WAIT: next_state = settle_done ? EXT_OWN : HALT_WAIT;
      EXT_OWN:   next_state = !ext_req_i || limit ? DRAIN : EXT_OWN;
      DRAIN:     next_state = rd_pend ? DRAIN : RELEASE;
      RELEASE:   next_state = CPU_OWN;
      default:   next_state = CPU_OWN;
    endcase
  end
  // outside a transfer the bus parks on the CPU address, or the last external one while granted/draining
  always_comb begin
    cpu_halt_o = state != CPU_OWN;
    ext_grant_o = state == EXT_OWN;
    ext_ready_o = state == EXT_OWN && !limit;
    ext_rvalid_o = rd_pend;
    ext_rdata_o = rd_pend ? bus_rdata_i : '0;
    bus_address_o = xfer ? ext_address_i : ext_side ? last_addr : cpu_address_i;
    bus_data_o = ext_side ? ext_wdata_i : cpu_data_i;
    bus_we_o = state == CPU_OWN ? cpu_we_i : xfer && ext_we_i;
    bus_we_ram_o = state == CPU_OWN ? cpu_we_ram_i : xfer && ext_we_i ? ext_be_i : 4'h0;
  end
endmodule

// File: tb/tb_bus_master_arbiter_rv32.sv
// tb_bus_master_arbiter_rv32: scenario tasks with a read-data scoreboard against a small RAM model
module tb_bus_master_arbiter_rv32;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic [31:0] cpu_address_i, cpu_data_i, ext_address_i, ext_wdata_i, bus_rdata_i;
  logic cpu_we_i, ext_req_i, ext_valid_i, ext_we_i;
  logic [3:0] cpu_we_ram_i, ext_be_i;
  logic cpu_halt_o, ext_grant_o, ext_ready_o, ext_rvalid_o, bus_we_o;
  logic [31:0] ext_rdata_o, bus_address_o, bus_data_o;
  logic [3:0] bus_we_ram_o;
  logic [31:0] mem [16];
  logic [31:0] shadow [16];
  logic [31:0] exp_q [$];
  int checks = 0;
  int passes = 0;

  always #5 clk_i = ~clk_i;

  bus_master_arbiter_rv32 #(
    .address_width(32), .data_width(32), .HaltSettleCycles(2), .MaxGrantCycles(8), .CpuMinCycles(16)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cpu_address_i(cpu_address_i), .cpu_data_i(cpu_data_i), .cpu_we_i(cpu_we_i),
    .cpu_we_ram_i(cpu_we_ram_i), .cpu_halt_o(cpu_halt_o),
    .ext_req_i(ext_req_i), .ext_grant_o(ext_grant_o), .ext_valid_i(ext_valid_i),
    .ext_ready_o(ext_ready_o), .ext_we_i(ext_we_i), .ext_be_i(ext_be_i),
    .ext_address_i(ext_address_i), .ext_wdata_i(ext_wdata_i),
    .ext_rvalid_o(ext_rvalid_o), .ext_rdata_o(ext_rdata_o),
    .bus_address_o(bus_address_o), .bus_data_o(bus_data_o), .bus_we_o(bus_we_o),
    .bus_we_ram_o(bus_we_ram_o), .bus_rdata_i(bus_rdata_i)
  );

  always @(posedge clk_i) begin
    if (bus_we_o)
      for (int b = 0; b < 4; b++)
        if (bus_we_ram_o[b]) mem[bus_address_o[5:2]][8*b +: 8] <= bus_data_o[8*b +: 8];
    bus_rdata_i <= mem[bus_address_o[5:2]];
  end

  task automatic tick();
    logic [31:0] e;
    @(posedge clk_i);
    @(negedge clk_i);
    if (ext_rvalid_o) begin
      checks++;
      if (exp_q.size() == 0) $display("FAIL rvalid_unexpected rdata=%h", ext_rdata_o);
      else begin
        e = exp_q.pop_front();
        if (ext_rdata_o !== e) $display("FAIL rdata got=%h exp=%h", ext_rdata_o, e);
        else passes++;
      end
    end
  endtask

  task automatic idle();
    ext_valid_i = 1'b0;
    ext_we_i = 1'b0;
    ext_be_i = 4'h0;
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ext_valid_i = 1'b1;
    ext_we_i = 1'b1;
    ext_be_i = be;
    ext_address_i = a;
    ext_wdata_i = d;
    for (int b = 0; b < 4; b++)
      if (be[b]) shadow[a[5:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic drive_read(input logic [31:0] a);
    ext_valid_i = 1'b1;
    ext_we_i = 1'b0;
    ext_be_i = 4'h0;
    ext_address_i = a;
    exp_q.push_back(shadow[a[5:2]]);
  endtask

  task automatic request_grant(output int n);
    ext_req_i = 1'b1;
    n = 0;
    while (!ext_grant_o && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    cpu_address_i = 32'h40;
    cpu_data_i = 32'h1234;
    cpu_we_i = 1'b1;
    cpu_we_ram_i = 4'h3;
    ext_req_i = 1'b0;
    idle();
    ext_valid_i = 1'b1;
    ext_address_i = 32'h200;
    ext_wdata_i = 32'h0;
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if ({cpu_halt_o, ext_grant_o, ext_ready_o, ext_rvalid_o} !== 4'b0000)
      $display("FAIL reset_outputs got=%b exp=0000", {cpu_halt_o, ext_grant_o, ext_ready_o, ext_rvalid_o}); else passes++;
    reset_i = 1'b0;
    tick();
    #1;
    checks++; if (bus_address_o !== 32'h40) $display("FAIL cpu_passthru_addr got=%h exp=00000040", bus_address_o); else passes++;
    checks++; if ({bus_we_o, bus_we_ram_o, ext_ready_o} !== 6'b1_0011_0)
      $display("FAIL cpu_passthru_we got=%b exp=100110", {bus_we_o, bus_we_ram_o, ext_ready_o}); else passes++;
    idle();
    cpu_we_i = 1'b0;
    cpu_we_ram_i = 4'h0;
  endtask

  task automatic test_grant();
    repeat (18) tick();
    ext_req_i = 1'b1;
    cpu_we_i = 1'b1;
    cpu_we_ram_i = 4'hF;
    #1;
    checks++; if (cpu_halt_o !== 1'b0) $display("FAIL halt_at_req got=%b exp=0", cpu_halt_o); else passes++;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++; if ({cpu_halt_o, ext_grant_o, bus_we_o, bus_we_ram_o} !== 7'b1_0_0_0000)
        $display("FAIL halt_wait_%0d got=%b exp=1000000", i, {cpu_halt_o, ext_grant_o, bus_we_o, bus_we_ram_o}); else passes++;
    end
    tick();
    #1;
    checks++; if ({cpu_halt_o, ext_grant_o, ext_ready_o} !== 3'b111)
      $display("FAIL grant_latency got=%b exp=111", {cpu_halt_o, ext_grant_o, ext_ready_o}); else passes++;
    cpu_we_i = 1'b0;
    cpu_we_ram_i = 4'h0;
  endtask

  task automatic test_write_read();
    drive_write(32'h100, 32'hDEADBEEF, 4'hF);
    #1;
    checks++; if ({bus_we_o, bus_we_ram_o} !== 5'b1_1111 || bus_address_o !== 32'h100 || bus_data_o !== 32'hDEADBEEF)
      $display("FAIL ext_write got=%b/%h/%h exp=11111/00000100/deadbeef", {bus_we_o, bus_we_ram_o}, bus_address_o, bus_data_o); else passes++;
    tick();
    drive_read(32'h100);
    #1;
    checks++; if ({ext_ready_o, bus_we_o, bus_we_ram_o} !== 6'b1_0_0000)
      $display("FAIL ext_read_strobes got=%b exp=100000", {ext_ready_o, bus_we_o, bus_we_ram_o}); else passes++;
    tick();
    idle();
    ext_address_i = 32'h3C;
    ext_req_i = 1'b0;
    #1;
    checks++; if (bus_address_o !== 32'h100 || bus_we_ram_o !== 4'h0 || bus_we_o !== 1'b0)
      $display("FAIL idle_hold got=%h/%b exp=00000100/0", bus_address_o, bus_we_ram_o); else passes++;
    tick();
    tick();
    #1;
    checks++; if ({cpu_halt_o, ext_grant_o, ext_ready_o, ext_rdata_o == 32'h0} !== 4'b1001)
      $display("FAIL release_state got=%b exp=1001", {cpu_halt_o, ext_grant_o, ext_ready_o, ext_rdata_o == 32'h0}); else passes++;
    checks++; if (bus_address_o !== cpu_address_i) $display("FAIL release_addr got=%h exp=%h", bus_address_o, cpu_address_i); else passes++;
    tick();
    checks++; if (cpu_halt_o !== 1'b0) $display("FAIL drop_latency_no_read got=%b exp=0", cpu_halt_o); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL write_read_pending got=%0d exp=0", exp_q.size()); else passes++;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] ra [4];
    ra[0] = 32'h108; ra[1] = 32'h104; ra[2] = 32'h100; ra[3] = 32'h108;
    request_grant(n);
    checks++; if (ext_grant_o !== 1'b1) $display("FAIL b2b_grant got=%b exp=1 after %0d", ext_grant_o, n); else passes++;
    drive_write(32'h104, $urandom, 4'hF);
    tick();
    drive_write(32'h108, $urandom, 4'hF);
    tick();
    drive_write(32'h104, $urandom, 4'b0011);
    #1;
    checks++; if (bus_we_ram_o !== 4'b0011) $display("FAIL partial_be got=%b exp=0011", bus_we_ram_o); else passes++;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_read(ra[i]);
      #1;
      checks++; if (ext_ready_o !== 1'b1) $display("FAIL b2b_ready_%0d got=%b exp=1", i, ext_ready_o); else passes++;
      tick();
      checks++; if (ext_rvalid_o !== 1'b1) $display("FAIL b2b_rvalid_%0d got=%b exp=1", i, ext_rvalid_o); else passes++;
    end
    idle();
    ext_req_i = 1'b0;
    tick();
    checks++; if (ext_rvalid_o !== 1'b0) $display("FAIL b2b_rvalid_end got=%b exp=0", ext_rvalid_o); else passes++;
    n = 0;
    while (cpu_halt_o && n < 10) begin tick(); n++; end
    checks++; if (exp_q.size() != 0 || cpu_halt_o !== 1'b0)
      $display("FAIL b2b_done got=%0d/%b exp=0/0", exp_q.size(), cpu_halt_o); else passes++;
  endtask

  task automatic test_grant_limit();
    int n;
    int r;
    int d;
    request_grant(n);
    checks++; if (ext_grant_o !== 1'b1) $display("FAIL limit_grant got=%b exp=1", ext_grant_o); else passes++;
    r = 0;
    while (ext_ready_o && r < 20) begin tick(); r++; end
    checks++; if (r != 8) $display("FAIL grant_limit_cycles got=%0d exp=8", r); else passes++;
    n = 0;
    while (cpu_halt_o && n < 10) begin tick(); n++; end
    checks++; if (cpu_halt_o !== 1'b0) $display("FAIL forced_release got=%b exp=0", cpu_halt_o); else passes++;
    d = 0;
    while (!cpu_halt_o && d < 60) begin tick(); d++; end
    checks++; if (cpu_halt_o !== 1'b1 || d < 16) $display("FAIL regrant_dwell got=%b/%0d exp=1/>=16", cpu_halt_o, d); else passes++;
    request_grant(n);
    ext_req_i = 1'b0;
    n = 0;
    while (cpu_halt_o && n < 10) begin tick(); n++; end
  endtask

  task automatic test_drop_with_read();
    int n;
    request_grant(n);
    checks++; if (ext_grant_o !== 1'b1) $display("FAIL drop_grant got=%b exp=1", ext_grant_o); else passes++;
    drive_read(32'h104);
    ext_req_i = 1'b0;
    #1;
    checks++; if (ext_ready_o !== 1'b1) $display("FAIL read_with_drop_ready got=%b exp=1", ext_ready_o); else passes++;
    tick();
    idle();
    #1;
    checks++; if ({cpu_halt_o, ext_ready_o} !== 2'b10) $display("FAIL drain got=%b exp=10", {cpu_halt_o, ext_ready_o}); else passes++;
    tick();
    checks++; if (cpu_halt_o !== 1'b1) $display("FAIL drain_extra got=%b exp=1", cpu_halt_o); else passes++;
    tick();
    checks++; if ({cpu_halt_o, ext_grant_o} !== 2'b10) $display("FAIL release_after_read got=%b exp=10", {cpu_halt_o, ext_grant_o}); else passes++;
    tick();
    checks++; if (cpu_halt_o !== 1'b0) $display("FAIL drop_latency_read got=%b exp=0", cpu_halt_o); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL drop_pending got=%0d exp=0", exp_q.size()); else passes++;
  endtask

  task automatic test_reset_mid_grant();
    int n;
    request_grant(n);
    checks++; if (ext_grant_o !== 1'b1) $display("FAIL mid_grant got=%b exp=1", ext_grant_o); else passes++;
    ext_valid_i = 1'b1;
    ext_we_i = 1'b0;
    ext_address_i = 32'h100;
    #1;
    checks++; if (ext_ready_o !== 1'b1) $display("FAIL mid_read_ready got=%b exp=1", ext_ready_o); else passes++;
    #1 reset_i = 1'b1;
    ext_req_i = 1'b0;
    #1;
    checks++; if ({cpu_halt_o, ext_grant_o} !== 2'b00) $display("FAIL async_reset got=%b exp=00", {cpu_halt_o, ext_grant_o}); else passes++;
    tick();
    checks++; if (ext_rvalid_o !== 1'b0) $display("FAIL dropped_rvalid got=%b exp=0", ext_rvalid_o); else passes++;
    reset_i = 1'b0;
    idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_grant();
    test_write_read();
    test_back_to_back();
    test_grant_limit();
    test_drop_with_read();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
